// File: rtl/line_buffer_ctrl.sv
// ============================================================================
// Module   : line_buffer_ctrl
// Purpose  : Address/enable sequencer for a multi-line pixel window buffer.
//            Optional zero-line drain after frame end: LBCTRL_DRAIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer_ctrl #(
    parameter int SCREENWIDTH = 1600,
    parameter int BUF_DEPTH   = 3,
    parameter int GAP_CYCLES  = 8,
    parameter int LINE_W      = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dv_i,
    input  logic                            hs_i,
    input  logic                            vs_i,
    output logic [$clog2(SCREENWIDTH)-1:0]  addr_o,
    output logic                            rd_en_o,
    output logic                            wr_en_o,
    output logic                            dv_o,
    output logic                            hs_o,
    output logic                            vs_o,
    output logic                            zero_fill_o,
    output logic                            win_valid_o,
    output logic [LINE_W-1:0]               line_cnt_o,
    output logic [$clog2(SCREENWIDTH):0]    line_width_o,
    output logic                            width_err_o,
    output logic                            overrun_o
);

    localparam int c_AW = $clog2(SCREENWIDTH);
    localparam int c_WW = c_AW + 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FILL  = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;

    localparam logic [c_WW-1:0]   c_SW        = c_WW'(SCREENWIDTH);
    localparam logic [c_AW-1:0]   c_ADDR_MAX  = c_AW'(SCREENWIDTH - 1);
    localparam logic [LINE_W-1:0] c_FILL_LAST = LINE_W'(BUF_DEPTH - 2);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_WW-1:0] r_cnt;
    logic            r_vld_d;
    logic            r_first;
    logic            w_vs_rise;
    logic            w_vld;
    logic            w_line_end;
    logic            w_abort;
    logic            w_sdv;

    assign w_vs_rise  = vs_i & ~vs_o;
    // A pixel coinciding with vs rising already belongs to the new frame.
    assign w_vld      = dv_i & ((r_state != c_IDLE) | w_vs_rise);
    assign w_line_end = r_vld_d & ~w_vld;

`ifdef LBCTRL_DRAIN_EN
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DGAP  = 3'd4;
    localparam int c_GW = $clog2(GAP_CYCLES + 1);
    localparam int c_DW = $clog2(BUF_DEPTH + 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DLAST    = c_DW'(BUF_DEPTH - 2);

    logic [c_GW-1:0] r_gap;
    logic [c_DW-1:0] r_dline;
    logic [c_WW-1:0] w_lw_m1;

    assign w_lw_m1 = line_width_o - 1'b1;
    assign w_abort = dv_i & ((r_state == c_DRAIN) | (r_state == c_DGAP));
    assign w_sdv   = (r_state == c_DRAIN) & ~dv_i & ~w_vs_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_fill_o <= 1'b0;
            r_gap       <= '0;
            r_dline     <= '0;
        end else begin
            zero_fill_o <= w_sdv;
            r_gap       <= (r_state == c_DGAP) ? r_gap + 1'b1 : '0;
            if (r_state == c_RUN)
                r_dline <= '0;
            else if ((r_state == c_DGAP) && (r_gap == c_GAP_LAST))
                r_dline <= r_dline + 1'b1;
        end
    end
`else
    logic w_unused_gap;

    assign w_unused_gap = (GAP_CYCLES > 0);
    assign w_abort      = 1'b0;
    assign w_sdv        = 1'b0;
    assign zero_fill_o  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_vs_rise) w_state_nxt = c_FILL;
            c_FILL: begin
                if (w_vs_rise)
                    w_state_nxt = c_FILL;
                else if (w_line_end && (line_cnt_o == c_FILL_LAST))
                    w_state_nxt = c_RUN;
            end
            c_RUN: begin
                if (w_vs_rise) begin
`ifdef LBCTRL_DRAIN_EN
                    if (dv_i || (line_width_o == '0))
                        w_state_nxt = c_FILL;
                    else
                        w_state_nxt = c_DRAIN;
`else
                    w_state_nxt = c_FILL;
`endif
                end
            end
`ifdef LBCTRL_DRAIN_EN
            c_DRAIN: begin
                if (dv_i || w_vs_rise)
                    w_state_nxt = c_FILL;
                else if (r_cnt == w_lw_m1)
                    w_state_nxt = c_DGAP;
            end
            c_DGAP: begin
                if (dv_i || w_vs_rise)
                    w_state_nxt = c_FILL;
                else if (r_gap == c_GAP_LAST)
                    w_state_nxt = (r_dline == c_DLAST) ? c_FILL : c_DRAIN;
            end
`endif
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_vld_d      <= 1'b0;
            r_first      <= 1'b0;
            dv_o         <= 1'b0;
            hs_o         <= 1'b0;
            vs_o         <= 1'b0;
            line_cnt_o   <= '0;
            line_width_o <= '0;
            width_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            dv_o    <= w_vld | w_sdv;
            hs_o    <= hs_i;
            vs_o    <= vs_i;
            r_vld_d <= w_vld;

            // Overrun pixel is pixel 0 of the new line, so the count resumes at 1.
            if (w_abort)
                r_cnt <= c_WW'(1);
            else if (w_sdv)
                r_cnt <= (r_cnt == w_lw_m1_or_zero()) ? '0 : r_cnt + 1'b1;
            else if (w_vld) begin
                if (r_cnt == c_SW)
                    width_err_o <= 1'b1;
                else
                    r_cnt <= r_cnt + 1'b1;
            end else
                r_cnt <= '0;

            if (w_line_end) begin
                if (r_first) begin
                    line_width_o <= r_cnt;
                    r_first      <= 1'b0;
                end else if (r_cnt != line_width_o)
                    width_err_o <= 1'b1;
                if (line_cnt_o != '1)
                    line_cnt_o <= line_cnt_o + 1'b1;
            end

            if (w_abort)
                overrun_o <= 1'b1;

            // Frame start is applied last so it overrides a coincident line end.
            if (w_vs_rise) begin
                line_cnt_o  <= '0;
                width_err_o <= 1'b0;
                overrun_o   <= 1'b0;
                r_first     <= 1'b1;
            end
        end
    end

    function automatic logic [c_WW-1:0] w_lw_m1_or_zero();
`ifdef LBCTRL_DRAIN_EN
        return w_lw_m1;
`else
        return '0;
`endif
    endfunction

    assign addr_o      = w_abort ? '0 : ((r_cnt >= c_SW) ? c_ADDR_MAX : r_cnt[c_AW-1:0]);
    assign rd_en_o     = (dv_i & (r_state != c_IDLE)) | dv_o;
    assign wr_en_o     = dv_o;
    assign win_valid_o = dv_o & ((r_state == c_RUN) | zero_fill_o);

endmodule

`default_nettype wire

// File: tb/tb_line_buffer_ctrl.sv
// ============================================================================
// Module   : tb_line_buffer_ctrl
// Purpose  : Directed self-checking bench for line_buffer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_buffer_ctrl;

    localparam int SW  = 16;
    localparam int BD  = 3;
    localparam int GAP = 4;
    localparam int LW  = 11;

    logic          clk = 1'b0;
    logic          rst_n, dv_i, hs_i, vs_i;
    logic [3:0]    addr_o;
    logic          rd_en_o, wr_en_o, dv_o, hs_o, vs_o, zero_fill_o, win_valid_o;
    logic [LW-1:0] line_cnt_o;
    logic [4:0]    line_width_o;
    logic          width_err_o, overrun_o;

    int n_checks = 0;
    int n_fail   = 0;

    line_buffer_ctrl #(
        .SCREENWIDTH(SW), .BUF_DEPTH(BD), .GAP_CYCLES(GAP), .LINE_W(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .addr_o(addr_o), .rd_en_o(rd_en_o), .wr_en_o(wr_en_o), .dv_o(dv_o),
        .hs_o(hs_o), .vs_o(vs_o), .zero_fill_o(zero_fill_o),
        .win_valid_o(win_valid_o), .line_cnt_o(line_cnt_o),
        .line_width_o(line_width_o), .width_err_o(width_err_o),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int n);
        for (int k = 0; k < n; k++) begin
            dv_i = 1'b1;
            step();
        end
        dv_i = 1'b0;
        repeat (5) step();
    endtask

    task automatic pulse_vs();
        vs_i = 1'b1;
        step();
        vs_i = 1'b0;
    endtask

    task automatic settle();
`ifdef LBCTRL_DRAIN_EN
        repeat (32) step();
`else
        repeat (2) step();
`endif
    endtask

    task automatic test_reset();
        n_checks++; if ({addr_o, rd_en_o, wr_en_o, dv_o, hs_o, vs_o, zero_fill_o, win_valid_o} !== 11'd0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0", {addr_o, rd_en_o, wr_en_o, dv_o, hs_o, vs_o, zero_fill_o, win_valid_o}); end
        n_checks++; if ({line_cnt_o, line_width_o, width_err_o, overrun_o} !== 18'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", {line_cnt_o, line_width_o, width_err_o, overrun_o}); end
        dv_i = 1'b1; hs_i = 1'b1; #1;
        n_checks++; if (rd_en_o !== 1'b0) begin n_fail++; $display("FAIL idle_rd_en: got %b want 0", rd_en_o); end
        step();
        n_checks++; if (dv_o !== 1'b0) begin n_fail++; $display("FAIL idle_dv_o: got %b want 0", dv_o); end
        n_checks++; if (hs_o !== 1'b1) begin n_fail++; $display("FAIL hs_pass: got %b want 1", hs_o); end
        dv_i = 1'b0; hs_i = 1'b0;
        step();
        n_checks++; if (line_cnt_o !== 11'd0) begin n_fail++; $display("FAIL idle_line_cnt: got %0d want 0", line_cnt_o); end
        n_checks++; if (hs_o !== 1'b0) begin n_fail++; $display("FAIL hs_fall: got %b want 0", hs_o); end
    endtask

    task automatic test_lines();
        vs_i = 1'b1;
        step();
        n_checks++; if (vs_o !== 1'b1) begin n_fail++; $display("FAIL vs_delay: got %b want 1", vs_o); end
        vs_i = 1'b0;
        repeat (2) step();
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < 10; k++) begin
                dv_i = 1'b1; #1;
                n_checks++; if (addr_o !== 4'(k)) begin n_fail++; $display("FAIL addr l%0d k%0d: got %0d want %0d", l, k, addr_o, k); end
                n_checks++; if (rd_en_o !== 1'b1) begin n_fail++; $display("FAIL rd_en l%0d k%0d: got %b want 1", l, k, rd_en_o); end
                step();
                n_checks++; if ({dv_o, wr_en_o} !== 2'b11) begin n_fail++; $display("FAIL dv_wr l%0d k%0d: got %b want 11", l, k, {dv_o, wr_en_o}); end
                n_checks++; if (win_valid_o !== (l >= 2)) begin n_fail++; $display("FAIL win_valid l%0d k%0d: got %b want %b", l, k, win_valid_o, (l >= 2)); end
            end
            dv_i = 1'b0; #1;
            n_checks++; if (rd_en_o !== 1'b1) begin n_fail++; $display("FAIL rd_en_tail l%0d: got %b want 1", l, rd_en_o); end
            step();
            n_checks++; if (dv_o !== 1'b0) begin n_fail++; $display("FAIL dv_lag l%0d: got %b want 0", l, dv_o); end
            n_checks++; if (line_cnt_o !== 11'(l + 1)) begin n_fail++; $display("FAIL line_cnt l%0d: got %0d want %0d", l, line_cnt_o, l + 1); end
            n_checks++; if (line_width_o !== 5'd10) begin n_fail++; $display("FAIL line_width l%0d: got %0d want 10", l, line_width_o); end
            repeat (4) step();
        end
    endtask

    task automatic test_width_err();
        pulse_vs();
        settle();
        send_line(10);
        send_line(10);
        n_checks++; if (width_err_o !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b want 0", width_err_o); end
        send_line(9);
        n_checks++; if (width_err_o !== 1'b1) begin n_fail++; $display("FAIL err_short: got %b want 1", width_err_o); end
        send_line(10);
        n_checks++; if (width_err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", width_err_o); end
        pulse_vs();
        n_checks++; if (width_err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", width_err_o); end
        n_checks++; if (line_cnt_o !== 11'd0) begin n_fail++; $display("FAIL vs_line_cnt: got %0d want 0", line_cnt_o); end
        n_checks++; if (line_width_o !== 5'd10) begin n_fail++; $display("FAIL width_hold: got %0d want 10", line_width_o); end
        settle();
    endtask

    task automatic test_saturate();
        int n15 = 0;
        for (int k = 0; k < 20; k++) begin
            dv_i = 1'b1; #1;
            n_checks++; if (addr_o !== 4'((k < 16) ? k : 15)) begin n_fail++; $display("FAIL sat_addr k%0d: got %0d want %0d", k, addr_o, (k < 16) ? k : 15); end
            if (addr_o == 4'd15) n15++;
            step();
        end
        dv_i = 1'b0;
        step();
        n_checks++; if (n15 != 5) begin n_fail++; $display("FAIL sat_hold: got %0d want 5", n15); end
        n_checks++; if (width_err_o !== 1'b1) begin n_fail++; $display("FAIL sat_err: got %b want 1", width_err_o); end
        repeat (4) step();
        pulse_vs();
        settle();
    endtask

`ifdef LBCTRL_DRAIN_EN
    task automatic test_drain();
        repeat (4) send_line(10);
        pulse_vs();
        n_checks++; if (line_cnt_o !== 11'd0) begin n_fail++; $display("FAIL drain_line_cnt: got %0d want 0", line_cnt_o); end
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 10; k++) begin
                n_checks++; if (addr_o !== 4'(k)) begin n_fail++; $display("FAIL drain_addr d%0d k%0d: got %0d want %0d", d, k, addr_o, k); end
                n_checks++; if ({dv_o, zero_fill_o, win_valid_o} !== {3{k != 0}}) begin n_fail++; $display("FAIL drain_strobe d%0d k%0d: got %b want %b", d, k, {dv_o, zero_fill_o, win_valid_o}, {3{k != 0}}); end
                step();
            end
            for (int g = 0; g < 4; g++) begin
                n_checks++; if ({dv_o, zero_fill_o} !== {2{g == 0}}) begin n_fail++; $display("FAIL drain_gap d%0d g%0d: got %b want %b", d, g, {dv_o, zero_fill_o}, {2{g == 0}}); end
                step();
            end
        end
        n_checks++; if ({dv_o, zero_fill_o} !== 2'b00) begin n_fail++; $display("FAIL drain_end: got %b want 00", {dv_o, zero_fill_o}); end
        send_line(10);
        n_checks++; if (line_cnt_o !== 11'd1) begin n_fail++; $display("FAIL post_drain_cnt: got %0d want 1", line_cnt_o); end
    endtask

    task automatic test_overrun();
        repeat (3) send_line(10);
        pulse_vs();
        repeat (3) step();
        n_checks++; if (zero_fill_o !== 1'b1) begin n_fail++; $display("FAIL ovr_zf_before: got %b want 1", zero_fill_o); end
        dv_i = 1'b1; #1;
        n_checks++; if (addr_o !== 4'd0) begin n_fail++; $display("FAIL ovr_addr0: got %0d want 0", addr_o); end
        step();
        n_checks++; if ({overrun_o, zero_fill_o, dv_o, win_valid_o} !== 4'b1010) begin n_fail++; $display("FAIL ovr_flags: got %b want 1010", {overrun_o, zero_fill_o, dv_o, win_valid_o}); end
        for (int k = 1; k < 10; k++) begin
            #1;
            n_checks++; if (addr_o !== 4'(k)) begin n_fail++; $display("FAIL ovr_addr k%0d: got %0d want %0d", k, addr_o, k); end
            step();
        end
        dv_i = 1'b0;
        step();
        n_checks++; if (line_cnt_o !== 11'd1) begin n_fail++; $display("FAIL ovr_line_cnt: got %0d want 1", line_cnt_o); end
        repeat (4) step();
        pulse_vs();
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun_o); end
        settle();
    endtask
`else
    task automatic test_no_drain();
        repeat (4) send_line(10);
        pulse_vs();
        for (int c = 0; c < 15; c++) begin
            n_checks++; if ({dv_o, zero_fill_o} !== 2'b00) begin n_fail++; $display("FAIL no_drain c%0d: got %b want 00", c, {dv_o, zero_fill_o}); end
            step();
        end
        send_line(10);
        n_checks++; if (line_cnt_o !== 11'd1) begin n_fail++; $display("FAIL no_drain_cnt: got %0d want 1", line_cnt_o); end
        pulse_vs();
        settle();
    endtask
`endif

    task automatic test_reset_mid();
        repeat (4) begin
            dv_i = 1'b1;
            step();
        end
        rst_n = 1'b0; hs_i = 1'b1;
        step();
        rst_n = 1'b1; hs_i = 1'b0; #1;
        n_checks++; if ({addr_o, rd_en_o, wr_en_o, dv_o, hs_o, vs_o, win_valid_o} !== 10'd0) begin n_fail++; $display("FAIL mid_rst_strobes: got %b want 0", {addr_o, rd_en_o, wr_en_o, dv_o, hs_o, vs_o, win_valid_o}); end
        n_checks++; if ({line_cnt_o, line_width_o, width_err_o, overrun_o} !== 18'd0) begin n_fail++; $display("FAIL mid_rst_status: got %h want 0", {line_cnt_o, line_width_o, width_err_o, overrun_o}); end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if ({dv_o, rd_en_o} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_ignore c%0d: got %b want 00", c, {dv_o, rd_en_o}); end
        end
        dv_i = 1'b0;
        repeat (2) step();
        vs_i = 1'b1; dv_i = 1'b1; #1;
        n_checks++; if (addr_o !== 4'd0) begin n_fail++; $display("FAIL vs_px_addr: got %0d want 0", addr_o); end
        step();
        vs_i = 1'b0;
        n_checks++; if (dv_o !== 1'b1) begin n_fail++; $display("FAIL vs_px_dv: got %b want 1", dv_o); end
        repeat (9) step();
        dv_i = 1'b0;
        step();
        n_checks++; if (line_width_o !== 5'd10) begin n_fail++; $display("FAIL vs_px_width: got %0d want 10", line_width_o); end
        n_checks++; if (line_cnt_o !== 11'd1) begin n_fail++; $display("FAIL vs_px_cnt: got %0d want 1", line_cnt_o); end
    endtask

    initial begin
        rst_n = 1'b0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        test_reset();
        test_lines();
        test_width_err();
        test_saturate();
`ifdef LBCTRL_DRAIN_EN
        test_drain();
        test_overrun();
`else
        test_no_drain();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
